pipe_ctrl: RTL

Parametrised pipeline control unit for the 5-stage RISC-V core, sitting beside the ID/EX/MEM/WB datapath registers. It carries an opaque per-instruction control bundle with a valid bit from ID to WB, and generates operand forwarding selects for a configurable number of source operands. It detects load-use hazards and inserts bubbles itself, freezes the pipe on a data-memory busy handshake, and resolves branches and jumps in MEM against the fetch prediction, producing redirect and flush.

---
 rtl/pipe_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control for the 5-stage RISC-V core.
// Carries the per-instruction control bundle ID->EX->MEM->WB, produces operand
// forwarding selects, load-use bubbles, mem_busy freeze and MEM-stage branch
// resolution with redirect/flush.
// Optional build macro PIPE_CTRL_PERF_EN adds stall/branch/mispredict counters;
// without it the perf_* ports are tied to zero.
module pipe_ctrl #(
    parameter int CTRL_W = 16,
    parameter int RA_W   = 5,
    parameter int NUM_RS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [CTRL_W-1:0]      id_ctrl,
    input  logic [RA_W-1:0]        id_rd,
    input  logic                   id_rd_we,
    input  logic                   id_is_load,
    input  logic [NUM_RS*RA_W-1:0] id_rs,
    input  logic [NUM_RS-1:0]      id_rs_used,
    input  logic                   id_is_branch,
    input  logic                   id_is_jump,
    input  logic                   id_pred_taken,
    input  logic [2:0]             id_funct3,
    input  logic                   br_eq,
    input  logic                   br_lt,
    input  logic                   mem_busy,
    output logic                   stall_id,
    output logic                   flush,
    output logic [CTRL_W-1:0]      ex_ctrl,
    output logic [CTRL_W-1:0]      mem_ctrl,
    output logic [CTRL_W-1:0]      wb_ctrl,
    output logic                   ex_valid,
    output logic                   mem_valid,
    output logic                   wb_valid,
    output logic [RA_W-1:0]        wb_rd,
    output logic                   wb_we,
    output logic [2*NUM_RS-1:0]    fwd_sel,
    output logic                   pc_sel,
    output logic                   redir_taken,
    output logic                   branch_resolved,
    output logic                   actual_taken,
    output logic                   mispredict,
    output logic [31:0]            perf_stall,
    output logic [31:0]            perf_branch,
    output logic [31:0]            perf_mispred
);

    // EX stage registers
    logic                   ex_v, ex_we, ex_is_load, ex_is_branch, ex_is_jump, ex_pred;
    logic [CTRL_W-1:0]      ex_c;
    logic [RA_W-1:0]        ex_rd;
    logic [2:0]             ex_f3;
    logic [NUM_RS*RA_W-1:0] ex_rs;
    logic [NUM_RS-1:0]      ex_rs_used;

    // MEM stage registers (comparator results sampled from EX)
    logic                   mem_v, mem_we, mem_is_branch, mem_is_jump, mem_pred;
    logic                   mem_eq, mem_lt;
    logic [CTRL_W-1:0]      mem_c;
    logic [RA_W-1:0]        mem_rd;
    logic [2:0]             mem_f3;

    // WB stage registers
    logic                   wb_v, wb_we_r;
    logic [CTRL_W-1:0]      wb_c;
    logic [RA_W-1:0]        wb_rd_r;

    logic load_use;
    logic cond_taken, taken, resolve;

    // Load-use hazard: a load in EX whose destination is read by the ID instruction.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        load_use = 1'b0;
        if (ex_v && ex_is_load && ex_we && ex_rd != '0) begin
            for (int i = 0; i < NUM_RS; i++) begin
                if (id_rs_used[i] && id_rs[i*RA_W +: RA_W] == ex_rd)
                    load_use = 1'b1;
            end
        end
    end

    // Branch/jump resolution for the instruction in MEM; gated while memory is busy.
    always_comb begin
        cond_taken = 1'b0;
        case (mem_f3)
            3'b000:         cond_taken = mem_eq;
            3'b001:         cond_taken = ~mem_eq;
            3'b100, 3'b110: cond_taken = mem_lt;
            3'b101, 3'b111: cond_taken = ~mem_lt;
            default:        cond_taken = 1'b0;
        endcase
        taken           = mem_is_jump | (mem_is_branch & cond_taken);
        resolve         = mem_v & ~mem_busy & (mem_is_branch | mem_is_jump);
        mispredict      = resolve & (taken != mem_pred);
        pc_sel          = mispredict;
        redir_taken     = resolve & taken;
        branch_resolved = resolve & mem_is_branch;
        actual_taken    = resolve & mem_is_branch & taken;
    end

    // Forwarding selects per EX operand; MEM result has priority over WB.
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (ex_rs_used[i] && mem_v && mem_we && mem_rd != '0 &&
                mem_rd == ex_rs[i*RA_W +: RA_W])
                fwd_sel[2*i +: 2] = 2'b10;
            else if (ex_rs_used[i] && wb_v && wb_we_r && wb_rd_r != '0 &&
                     wb_rd_r == ex_rs[i*RA_W +: RA_W])
                fwd_sel[2*i +: 2] = 2'b01;
        end
    end

    // A redirect kills IF/ID, so it overrides both stall causes.
    assign flush    = pc_sel;
    assign stall_id = ~pc_sel & (mem_busy | load_use);

    // ID->EX: hold on busy, bubble on redirect, load-use or empty ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
            ex_v <= 1'b0; ex_c <= '0; ex_rd <= '0; ex_we <= 1'b0; ex_is_load <= 1'b0;
            ex_is_branch <= 1'b0; ex_is_jump <= 1'b0; ex_pred <= 1'b0; ex_f3 <= '0;
            ex_rs <= '0; ex_rs_used <= '0;
        end else if (!mem_busy) begin
            if (pc_sel || load_use || !id_valid) begin
                ex_v <= 1'b0; ex_c <= '0; ex_rd <= '0; ex_we <= 1'b0; ex_is_load <= 1'b0;
                ex_is_branch <= 1'b0; ex_is_jump <= 1'b0; ex_pred <= 1'b0; ex_f3 <= '0;
                ex_rs <= '0; ex_rs_used <= '0;
            end else begin
                ex_v <= 1'b1; ex_c <= id_ctrl; ex_rd <= id_rd; ex_we <= id_rd_we;
                ex_is_load <= id_is_load; ex_is_branch <= id_is_branch;
                ex_is_jump <= id_is_jump; ex_pred <= id_pred_taken; ex_f3 <= id_funct3;
                ex_rs <= id_rs; ex_rs_used <= id_rs_used;
            end
        end
    end

    // EX->MEM: hold on busy, bubble on redirect; comparator results captured here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_v <= 1'b0; mem_c <= '0; mem_rd <= '0; mem_we <= 1'b0;
            mem_is_branch <= 1'b0; mem_is_jump <= 1'b0; mem_pred <= 1'b0; mem_f3 <= '0;
            mem_eq <= 1'b0; mem_lt <= 1'b0;
        end else if (!mem_busy) begin
            if (pc_sel) begin
                mem_v <= 1'b0; mem_c <= '0; mem_rd <= '0; mem_we <= 1'b0;
                mem_is_branch <= 1'b0; mem_is_jump <= 1'b0; mem_pred <= 1'b0; mem_f3 <= '0;
                mem_eq <= 1'b0; mem_lt <= 1'b0;
            end else begin
                mem_v <= ex_v; mem_c <= ex_c; mem_rd <= ex_rd; mem_we <= ex_we;
                mem_is_branch <= ex_is_branch; mem_is_jump <= ex_is_jump;
                mem_pred <= ex_pred; mem_f3 <= ex_f3;
                mem_eq <= br_eq; mem_lt <= br_lt;
            end
        end
    end

    // MEM->WB: the resolving instruction itself always retires into WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_v <= 1'b0; wb_c <= '0; wb_rd_r <= '0; wb_we_r <= 1'b0;
        end else if (!mem_busy) begin
            wb_v <= mem_v; wb_c <= mem_c; wb_rd_r <= mem_rd; wb_we_r <= mem_we;
        end
    end

    assign ex_valid  = ex_v;
    assign mem_valid = mem_v;
    assign wb_valid  = wb_v;
    assign ex_ctrl   = ex_v  ? ex_c  : '0;
    assign mem_ctrl  = mem_v ? mem_c : '0;
    assign wb_ctrl   = wb_v  ? wb_c  : '0;
    assign wb_rd     = wb_rd_r;
    assign wb_we     = wb_v & wb_we_r & (wb_rd_r != '0);

`ifdef PIPE_CTRL_PERF_EN
    // Wrapping performance counters for stalls, resolved branches and mispredicts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall   <= '0;
            perf_branch  <= '0;
            perf_mispred <= '0;
        end else begin
            if (stall_id && !flush) perf_stall   <= perf_stall + 32'd1;
            if (branch_resolved)    perf_branch  <= perf_branch + 32'd1;
            if (mispredict)         perf_mispred <= perf_mispred + 32'd1;
        end
    end
`else
    assign perf_stall   = '0;
    assign perf_branch  = '0;
    assign perf_mispred = '0;
`endif

endmodule
